// File: rtl/cnn_mem_pkg.sv
// Shared types and helpers for the CNN memory sequencing blocks.
package cnn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // Wraps base+offset into [0, depth); offset is expected to be smaller than depth.
    function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                              input logic [31:0] offset,
                                              input logic [31:0] depth);
        logic [31:0] sum;
        sum = base + offset;
        if (sum >= depth) begin
            return sum - depth;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO feeding a valid/ready stream; exposes its fill level.
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             pop_s;
    logic             push_ok_s;

    // Pop on handshake; a push into a full FIFO is only taken if a pop frees a slot.
    always_comb begin
        pop_s     = (count_r != 2'd0) && out_ready;
        push_ok_s = push && ((count_r != 2'd2) || pop_s);
    end

    // Storage, pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r[0] <= {WIDTH{1'b0}};
            entry_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                entry_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign out_valid = (count_r != 2'd0);
    assign out_data  = entry_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/ram_tile_streamer.sv
// Moves a tile between valid/ready streams and a single-port async RAM with a shared data bus.
module ram_tile_streamer
    import cnn_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  dir,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1'b1);

    state_t                state_r, state_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [LEN_WIDTH-1:0]  issue_cnt_r, issue_cnt_s;
    logic [LEN_WIDTH-1:0]  pop_cnt_r, pop_cnt_s;
    logic [ADDR_WIDTH-1:0] next_addr_r, next_addr_s;
    logic [ADDR_WIDTH-1:0] inc_addr_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic                  mem_cs_r, mem_cs_s;
    logic                  mem_we_r, mem_we_s;
    logic                  mem_oe_r, mem_oe_s;
    logic                  busy_r, done_r;
    logic                  in_ready_s, in_hs_s;
    logic                  fifo_valid_s, pop_s;
    logic [1:0]            fifo_count_s;
    logic [2:0]            count_next_s;
    logic [DATA_WIDTH-1:0] fifo_data_s;

    stream_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_oe_r),
        .push_data (mem_data),
        .out_data  (fifo_data_s),
        .out_valid (fifo_valid_s),
        .out_ready (out_ready),
        .count     (fifo_count_s)
    );

    // Stream handshakes and the FIFO level expected after the coming edge.
    always_comb begin
        in_ready_s   = (state_r == WRITE) && (issue_cnt_r < len_r);
        in_hs_s      = in_ready_s && in_valid;
        pop_s        = fifo_valid_s && out_ready;
        count_next_s = {1'b0, fifo_count_s} + {2'b00, mem_oe_r} - {2'b00, pop_s};
        inc_addr_s   = ADDR_WIDTH'(wrap_addr(32'(next_addr_r), 32'd1, 32'(MEM_DEPTH)));
    end

    // Next-state, counters and next RAM bus cycle; the bus idles unless a cycle is scheduled.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        issue_cnt_s = issue_cnt_r;
        pop_cnt_s   = pop_cnt_r;
        next_addr_s = next_addr_r;
        wdata_s     = wdata_r;
        mem_addr_s  = mem_addr_r;
        mem_cs_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_oe_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    len_s       = len;
                    issue_cnt_s = {LEN_WIDTH{1'b0}};
                    pop_cnt_s   = {LEN_WIDTH{1'b0}};
                    if (len == {LEN_WIDTH{1'b0}}) begin
                        state_s = DONE;
                    end else if (dir == DIR_WRITE) begin
                        state_s     = WRITE;
                        next_addr_s = base_addr;
                    end else begin
                        // First read goes out right away so data appears two cycles after start.
                        state_s     = READ;
                        mem_cs_s    = 1'b1;
                        mem_oe_s    = 1'b1;
                        mem_addr_s  = base_addr;
                        next_addr_s = ADDR_WIDTH'(wrap_addr(32'(base_addr), 32'd1, 32'(MEM_DEPTH)));
                        issue_cnt_s = LEN_ONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (in_hs_s) begin
                    wdata_s     = in_data;
                    mem_addr_s  = next_addr_r;
                    next_addr_s = inc_addr_s;
                    issue_cnt_s = issue_cnt_r + LEN_ONE;
                    mem_cs_s    = 1'b1;
                    mem_we_s    = 1'b1;
                end else if ((issue_cnt_r == len_r) && mem_we_r) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            READ: begin
                if ((issue_cnt_r < len_r) && (count_next_s <= 3'd1)) begin
                    mem_cs_s    = 1'b1;
                    mem_oe_s    = 1'b1;
                    mem_addr_s  = next_addr_r;
                    next_addr_s = inc_addr_s;
                    issue_cnt_s = issue_cnt_r + LEN_ONE;
                end else begin
                    issue_cnt_s = issue_cnt_r;
                end
                if (pop_s) begin
                    pop_cnt_s = pop_cnt_r + LEN_ONE;
                    if (pop_cnt_r == (len_r - LEN_ONE)) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    pop_cnt_s = pop_cnt_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered RAM/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            len_r       <= {LEN_WIDTH{1'b0}};
            issue_cnt_r <= {LEN_WIDTH{1'b0}};
            pop_cnt_r   <= {LEN_WIDTH{1'b0}};
            next_addr_r <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_cs_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            issue_cnt_r <= issue_cnt_s;
            pop_cnt_r   <= pop_cnt_s;
            next_addr_r <= next_addr_s;
            wdata_r     <= wdata_s;
            mem_addr_r  <= mem_addr_s;
            mem_cs_r    <= mem_cs_s;
            mem_we_r    <= mem_we_s;
            mem_oe_r    <= mem_oe_s;
            busy_r      <= (state_s == WRITE) || (state_s == READ);
            done_r      <= (state_s == DONE);
        end
    end

    // Data bus is driven only in write cycles, which never coincide with mem_oe.
    assign mem_data  = mem_we_r ? wdata_r : {DATA_WIDTH{1'bz}};
    assign mem_addr  = mem_addr_r;
    assign mem_cs    = mem_cs_r;
    assign mem_we    = mem_we_r;
    assign mem_oe    = mem_oe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign in_ready  = in_ready_s;
    assign out_valid = fifo_valid_s;
    assign out_data  = fifo_data_s;

endmodule

// File: tb/tb_ram_tile_streamer.sv
// Directed bench for ram_tile_streamer with a behavioural async RAM on the shared bus.
module tb_ram_tile_streamer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dir;
    logic [7:0] base_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] mem_addr;
    wire  [7:0] mem_data;
    logic       mem_cs;
    logic       mem_we;
    logic       mem_oe;

    logic [7:0] ram [16];
    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int cs_cnt   = 0;

    ram_tile_streamer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(16), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
        .base_addr(base_addr), .len(len), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: async read onto the bus, write captured at the closing edge.
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram[mem_addr[3:0]] : 8'bz;
    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr[3:0]] <= mem_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle bus sanity and event counters.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_cs) cs_cnt++;
        check_eq("bus_oe_we", {31'd0, mem_oe & mem_we}, 32'd0);
        check_eq("bus_idle", {31'd0, !mem_cs & (mem_we | mem_oe)}, 32'd0);
    end

    task automatic do_write(input logic [7:0] b, input logic [7:0] n, input logic [7:0] d0);
        int acc, wb, cyc, d_before;
        d_before = done_cnt;
        start = 1'b1; dir = 1'b1; base_addr = b; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0; wb = 0; cyc = 0;
        while ((wb < int'(n)) && (cyc < 50)) begin
            if (mem_we) begin
                check_eq("wr_data", 32'(mem_data), 32'((d0 + wb) & 8'hFF));
                check_eq("wr_addr", 32'(mem_addr), 32'((b + wb) % 16));
                wb++;
            end
            in_valid = (acc < int'(n));
            in_data  = 8'(d0 + acc);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("wr_beats", 32'(wb), 32'(n));
        repeat (3) begin @(posedge clk); #1; end
        check_eq("wr_done_once", 32'(done_cnt - d_before), 32'd1);
        check_eq("wr_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // mode 0: out_ready=1; mode 1: ready 1,0,0 repeating; mode 2: like 0 plus a start pulse mid-transfer.
    task automatic do_read(input logic [7:0] b, input logic [7:0] n, input int mode, input int abort_after);
        int got, cyc, first, last, d_before, limit;
        logic [7:0] held;
        logic stalled;
        d_before = done_cnt;
        limit = (abort_after > 0) ? abort_after : int'(n);
        out_ready = 1'b1;
        start = 1'b1; dir = 1'b0; base_addr = b; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; got = 0; first = -1; last = -1; stalled = 1'b0; held = 8'h00;
        check_eq("rd_lat_cyc1", {31'd0, out_valid}, 32'd0);
        while ((got < limit) && (cyc < 100)) begin
            if (stalled) check_eq("rd_hold", 32'(out_data), 32'(held));
            out_ready = (mode == 1) ? ((cyc % 3) == 2) : 1'b1;
            if (mode == 2) begin
                start = (cyc == 3);
                if (cyc == 3) begin dir = 1'b1; base_addr = 8'd5; len = 8'd2; end
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    check_eq("rd_data", 32'(out_data), 32'(exp_q[got]));
                    got++; last = cyc; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = out_data;
                end
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_eq("rd_count", 32'(got), 32'(limit));
        if (abort_after == 0) begin
            if (mode == 0) begin
                check_eq("rd_first_lat", 32'(first), 32'd2);
                check_eq("rd_back2back", 32'(last - first), 32'(n - 1));
            end
            repeat (3) begin @(posedge clk); #1; end
            check_eq("rd_done_once", 32'(done_cnt - d_before), 32'd1);
            check_eq("rd_idle_busy", {31'd0, busy}, 32'd0);
            check_eq("rd_idle_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int d_before, c_before;
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'hC0 + i);
        rst_n = 1'b1; start = 1'b0; dir = 1'b0; base_addr = 8'd0; len = 8'd0;
        in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back
        do_write(8'd0, 8'd4, 8'hA1);
        check_eq("t1_ram0", 32'(ram[0]), 32'hA1);
        check_eq("t1_ram3", 32'(ram[3]), 32'hA4);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_read(8'd0, 8'd4, 0, 0);

        // Address wrap
        do_write(8'd14, 8'd4, 8'd10);
        check_eq("t2_ram14", 32'(ram[14]), 32'd10);
        check_eq("t2_ram15", 32'(ram[15]), 32'd11);
        check_eq("t2_ram0", 32'(ram[0]), 32'd12);
        check_eq("t2_ram1", 32'(ram[1]), 32'd13);
        check_eq("t2_ram2", 32'(ram[2]), 32'hA3);
        exp_q = '{8'd10, 8'd11, 8'd12, 8'd13};
        do_read(8'd14, 8'd4, 0, 0);

        // Backpressure
        exp_q = '{8'd12, 8'd13, 8'hA3, 8'hA4, 8'hC4, 8'hC5};
        do_read(8'd0, 8'd6, 1, 0);

        // Zero length
        d_before = done_cnt; c_before = cs_cnt;
        start = 1'b1; dir = 1'b1; base_addr = 8'd3; len = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("len0_done", {31'd0, done}, 32'd1);
        check_eq("len0_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check_eq("len0_done_drop", {31'd0, done}, 32'd0);
        check_eq("len0_done_cnt", 32'(done_cnt - d_before), 32'd1);
        check_eq("len0_no_cs", 32'(cs_cnt - c_before), 32'd0);

        // Start while busy is ignored
        exp_q = '{8'hA3, 8'hA4, 8'hC4, 8'hC5};
        do_read(8'd2, 8'd4, 2, 0);
        check_eq("busy_start_ram5", 32'(ram[5]), 32'hC5);
        check_eq("busy_start_ram6", 32'(ram[6]), 32'hC6);

        // Reset mid-read after two words
        exp_q = '{8'hA3, 8'hA4, 8'hC4, 8'hC5, 8'hC6};
        d_before = done_cnt;
        do_read(8'd2, 8'd5, 0, 2);
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_cs", {31'd0, mem_cs}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_eq("abort_no_done", 32'(done_cnt - d_before), 32'd0);
        check_eq("abort_ram2", 32'(ram[2]), 32'hA3);
        exp_q = '{8'hA3, 8'hA4, 8'hC4};
        do_read(8'd2, 8'd3, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
